// File: rtl/aibcr3_dcc_pkg.sv
// Shared state encoding, defaults and timeout helper for the DCC calibration sequencer.
package aibcr3_dcc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BYPASS = 3'd1,
        ST_GAP    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } seq_state_e;

    localparam int GAP_CYC_DEF  = 8;
    localparam int TMO_W_DEF    = 16;
    localparam int TMO_BASE_EXP = 8;

    // Last count value of an attempt: each attempt lasts 2^(sel+8) cycles.
    function automatic logic [31:0] tmo_limit(input logic [2:0] sel);
        return (32'd1 << (TMO_BASE_EXP + int'(sel))) - 32'd1;
    endfunction

endpackage

// File: rtl/aibcr3_dcc_bitsync.sv
// Two-flop synchronizer with asynchronous active-low clear.
module aibcr3_dcc_bitsync (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/aibcr3_dcc_cal_seq.sv
// DCC calibration sequencer: gaps the DCC request, waits for done with timeout and
// bounded retries, and tracks loss of done for optional recalibration.
module aibcr3_dcc_cal_seq
    import aibcr3_dcc_pkg::*;
#(
    parameter int TMO_W   = TMO_W_DEF,
    parameter int GAP_CYC = GAP_CYC_DEF
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rb_dcc_en,
    input  logic       rb_dcc_byp,
    input  logic       rb_cont_cal,
    input  logic [1:0] rb_max_retry,
    input  logic [2:0] rb_tmo_sel,
    input  logic       cal_start,
    input  logic       dcc_done,
    output logic       dcc_req,
    output logic       cal_done,
    output logic       cal_err,
    output logic [1:0] retry_cnt,
    output logic [2:0] seq_state
);

    localparam int              GAP_W    = $clog2(GAP_CYC + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [1:0]       retry_d;
    logic [GAP_W-1:0] gap_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             cal_start_q;
    logic             dcc_done_s;
    logic             start_edge;
    logic             gap_end;
    logic             tmo_hit;

    aibcr3_dcc_bitsync u_done_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (dcc_done),
        .q    (dcc_done_s)
    );

    assign start_edge = cal_start & ~cal_start_q;
    assign gap_end    = (gap_cnt == GAP_LAST);
    assign tmo_hit    = (32'(tmo_cnt) == tmo_limit(rb_tmo_sel));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            retry_cnt   <= 2'd0;
            cal_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            retry_cnt   <= retry_d;
            cal_start_q <= cal_start;
        end
    end

    // Counters restart on every entry into their state and hold at their last value.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            gap_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            if (state_q == ST_GAP && state_d == ST_GAP) begin
                if (gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + GAP_W'(1);
            end else begin
                gap_cnt <= '0;
            end
            if (state_q == ST_WAIT && state_d == ST_WAIT) begin
                if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_cnt;
        if (!rb_dcc_en) begin
            state_d = ST_IDLE;
            retry_d = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rb_dcc_byp) begin
                        state_d = ST_BYPASS;
                    end else if (start_edge) begin
                        state_d = ST_GAP;
                        retry_d = 2'd0;
                    end
                end
                ST_BYPASS: begin
                    if (!rb_dcc_byp) state_d = ST_IDLE;
                end
                ST_GAP: begin
                    if (gap_end && !dcc_done_s) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (dcc_done_s) begin
                        state_d = ST_DONE;
                    end else if (tmo_hit) begin
                        if (retry_cnt < rb_max_retry) begin
                            state_d = ST_GAP;
                            retry_d = retry_cnt + 2'd1;
                        end else begin
                            state_d = ST_ERR;
                        end
                    end
                end
                ST_DONE: begin
                    if (start_edge) begin
                        state_d = ST_GAP;
                        retry_d = 2'd0;
                    end else if (!dcc_done_s) begin
                        state_d = rb_cont_cal ? ST_GAP : ST_ERR;
                        if (rb_cont_cal) retry_d = 2'd0;
                    end
                end
                ST_ERR: begin
                    if (start_edge) begin
                        state_d = ST_GAP;
                        retry_d = 2'd0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    retry_d = 2'd0;
                end
            endcase
        end
        // A CSR lowered mid-sequence must not leave the count above the new limit.
        if (retry_d > rb_max_retry) retry_d = rb_max_retry;
    end

    always_comb begin
        dcc_req   = (state_q == ST_WAIT) || (state_q == ST_DONE);
        cal_done  = (state_q == ST_DONE) || (state_q == ST_BYPASS);
        cal_err   = (state_q == ST_ERR);
        seq_state = state_q;
    end

endmodule

// File: tb/tb_aibcr3_dcc_cal_seq.sv
// Self-checking bench for aibcr3_dcc_cal_seq using randomized timing scenarios.
module tb_aibcr3_dcc_cal_seq;

    localparam int GAP     = 8;
    localparam int SIG_REQ = 0;
    localparam int SIG_CD  = 1;
    localparam int SIG_ERR = 2;

    logic       clk = 1'b0;
    logic       nrst;
    logic       rb_dcc_en;
    logic       rb_dcc_byp;
    logic       rb_cont_cal;
    logic [1:0] rb_max_retry;
    logic [2:0] rb_tmo_sel;
    logic       cal_start;
    logic       dcc_done;
    logic       dcc_req;
    logic       cal_done;
    logic       cal_err;
    logic [1:0] retry_cnt;
    logic [2:0] seq_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aibcr3_dcc_cal_seq dut (
        .clk          (clk),
        .nrst         (nrst),
        .rb_dcc_en    (rb_dcc_en),
        .rb_dcc_byp   (rb_dcc_byp),
        .rb_cont_cal  (rb_cont_cal),
        .rb_max_retry (rb_max_retry),
        .rb_tmo_sel   (rb_tmo_sel),
        .cal_start    (cal_start),
        .dcc_done     (dcc_done),
        .dcc_req      (dcc_req),
        .cal_done     (cal_done),
        .cal_err      (cal_err),
        .retry_cnt    (retry_cnt),
        .seq_state    (seq_state)
    );

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts clock steps until the chosen output reaches level; -1 if the budget runs out.
    task automatic wait_until(input int sel, input logic level, input int budget, output int n);
        logic v;
        n = 0;
        do begin
            step();
            n++;
            v = (sel == SIG_REQ) ? dcc_req : (sel == SIG_CD) ? cal_done : cal_err;
        end while (v !== level && n < budget);
        if (v !== level) n = -1;
    endtask

    task automatic go_idle();
        rb_dcc_en  = 1'b0;
        cal_start  = 1'b0;
        dcc_done   = 1'b0;
        rb_dcc_byp = 1'b0;
        step();
        rb_dcc_en = 1'b1;
        step(3);
    endtask

    task automatic test_reset();
        int n;
        nrst = 1'b0; rb_dcc_en = 1'b1; rb_dcc_byp = 1'b0; rb_cont_cal = 1'b0;
        rb_max_retry = 2'd0; rb_tmo_sel = 3'd0; cal_start = 1'b1; dcc_done = 1'b0;
        #12;
        checks++;
        if ({dcc_req, cal_done, cal_err, retry_cnt, seq_state} !== 8'd0) begin
            errors++; $display("[TB] FAIL reset_outputs: got %b expected 0", {dcc_req, cal_done, cal_err, retry_cnt, seq_state});
        end
        @(negedge clk);
        nrst = 1'b1;
        step();
        cal_start = 1'b0;
        checks++;
        if (seq_state !== 3'd2) begin errors++; $display("[TB] FAIL reset_start_edge: got %0d expected 2", seq_state); end
        wait_until(SIG_REQ, 1'b1, 40, n);
        checks++;
        if (n !== GAP) begin errors++; $display("[TB] FAIL reset_req_latency: got %0d expected %0d", n, GAP); end
    endtask

    task automatic test_success();
        for (int it = 0; it < 4; it++) begin
            int t, a, off, n;
            go_idle();
            rb_tmo_sel   = 3'($urandom_range(0, 1));
            rb_max_retry = 2'($urandom_range(0, 3));
            rb_cont_cal  = 1'($urandom_range(0, 1));
            t   = 1 << (int'(rb_tmo_sel) + 8);
            a   = $urandom_range(0, int'(rb_max_retry));
            off = $urandom_range(0, t - 3);
            cal_start = 1'b1;
            step();
            cal_start = 1'b0;
            step(GAP + 1 + a * (t + GAP) + off - 1);
            checks++;
            if (seq_state !== 3'd3 || retry_cnt !== 2'(a)) begin
                errors++; $display("[TB] FAIL success_in_wait: got state %0d retry %0d expected 3 %0d", seq_state, retry_cnt, a);
            end
            dcc_done = 1'b1;
            wait_until(SIG_CD, 1'b1, 10, n);
            checks++;
            if (n !== 3) begin errors++; $display("[TB] FAIL success_done_latency: got %0d expected 3", n); end
            checks++;
            if (seq_state !== 3'd4 || retry_cnt !== 2'(a)) begin
                errors++; $display("[TB] FAIL success_done_state: got state %0d retry %0d expected 4 %0d", seq_state, retry_cnt, a);
            end
            dcc_done = 1'b0;
            if (rb_cont_cal) begin
                wait_until(SIG_REQ, 1'b0, 10, n);
                checks++;
                if (n !== 3) begin errors++; $display("[TB] FAIL recal_req_drop: got %0d expected 3", n); end
                wait_until(SIG_REQ, 1'b1, 20, n);
                checks++;
                if (n !== GAP || retry_cnt !== 2'd0) begin
                    errors++; $display("[TB] FAIL recal_gap_len: got %0d retry %0d expected %0d 0", n, retry_cnt, GAP);
                end
            end else begin
                wait_until(SIG_ERR, 1'b1, 10, n);
                checks++;
                if (n !== 3 || seq_state !== 3'd5) begin
                    errors++; $display("[TB] FAIL lost_done_err: got %0d state %0d expected 3 5", n, seq_state);
                end
            end
        end
    endtask

    task automatic test_timeout_retry();
        for (int it = 0; it < 2; it++) begin
            int t, n;
            go_idle();
            rb_tmo_sel   = 3'($urandom_range(0, 1));
            rb_max_retry = 2'($urandom_range(0, 3));
            t = 1 << (int'(rb_tmo_sel) + 8);
            cal_start = 1'b1;
            step();
            cal_start = 1'b0;
            wait_until(SIG_REQ, 1'b1, 40, n);
            checks++;
            if (n !== GAP) begin errors++; $display("[TB] FAIL tmo_first_req: got %0d expected %0d", n, GAP); end
            for (int r = 0; r <= int'(rb_max_retry); r++) begin
                wait_until(SIG_REQ, 1'b0, t + 10, n);
                checks++;
                if (n !== t) begin errors++; $display("[TB] FAIL tmo_high_len: got %0d expected %0d", n, t); end
                if (r < int'(rb_max_retry)) begin
                    checks++;
                    if (retry_cnt !== 2'(r + 1)) begin errors++; $display("[TB] FAIL tmo_retry_cnt: got %0d expected %0d", retry_cnt, r + 1); end
                    wait_until(SIG_REQ, 1'b1, 40, n);
                    checks++;
                    if (n !== GAP) begin errors++; $display("[TB] FAIL tmo_low_len: got %0d expected %0d", n, GAP); end
                end
            end
            checks++;
            if (cal_err !== 1'b1 || seq_state !== 3'd5 || retry_cnt !== rb_max_retry) begin
                errors++; $display("[TB] FAIL tmo_err: got err %0b state %0d retry %0d expected 1 5 %0d", cal_err, seq_state, retry_cnt, rb_max_retry);
            end
            cal_start = 1'b1;
            step();
            cal_start = 1'b0;
            wait_until(SIG_REQ, 1'b1, 40, n);
            checks++;
            if (n !== GAP || retry_cnt !== 2'd0) begin
                errors++; $display("[TB] FAIL err_restart: got %0d retry %0d expected %0d 0", n, retry_cnt, GAP);
            end
        end
    endtask

    task automatic test_bypass();
        go_idle();
        rb_dcc_byp = 1'b1;
        step();
        checks++;
        if (cal_done !== 1'b1 || seq_state !== 3'd1) begin
            errors++; $display("[TB] FAIL bypass_enter: got done %0b state %0d expected 1 1", cal_done, seq_state);
        end
        for (int i = 0; i < 3; i++) begin
            cal_start = 1'b1;
            step($urandom_range(1, 3));
            cal_start = 1'b0;
            step();
            checks++;
            if (dcc_req !== 1'b0 || seq_state !== 3'd1) begin
                errors++; $display("[TB] FAIL bypass_ignore_start: got req %0b state %0d expected 0 1", dcc_req, seq_state);
            end
        end
        rb_dcc_byp = 1'b0;
        step();
        checks++;
        if (cal_done !== 1'b0 || seq_state !== 3'd0) begin
            errors++; $display("[TB] FAIL bypass_exit: got done %0b state %0d expected 0 0", cal_done, seq_state);
        end
    endtask

    task automatic test_disable();
        go_idle();
        rb_tmo_sel   = 3'd0;
        rb_max_retry = 2'd2;
        cal_start = 1'b1;
        step();
        cal_start = 1'b0;
        step(GAP + 1 + 256 + GAP + $urandom_range(0, 200) - 1);
        checks++;
        if (seq_state !== 3'd3 || retry_cnt !== 2'd1) begin
            errors++; $display("[TB] FAIL disable_setup: got state %0d retry %0d expected 3 1", seq_state, retry_cnt);
        end
        rb_dcc_en = 1'b0;
        step();
        checks++;
        if (dcc_req !== 1'b0 || seq_state !== 3'd0 || retry_cnt !== 2'd0) begin
            errors++; $display("[TB] FAIL disable_wait: got req %0b state %0d retry %0d expected 0 0 0", dcc_req, seq_state, retry_cnt);
        end
        rb_dcc_en = 1'b1;
    endtask

    task automatic test_reset_mid_gap();
        go_idle();
        cal_start = 1'b1;
        step();
        cal_start = 1'b0;
        step(2);
        checks++;
        if (seq_state !== 3'd2) begin errors++; $display("[TB] FAIL midgap_setup: got %0d expected 2", seq_state); end
        #2 nrst = 1'b0;
        #1;
        checks++;
        if ({dcc_req, cal_done, cal_err, retry_cnt, seq_state} !== 8'd0) begin
            errors++; $display("[TB] FAIL midgap_reset: got %b expected 0", {dcc_req, cal_done, cal_err, retry_cnt, seq_state});
        end
        @(negedge clk);
        nrst = 1'b1;
        step();
    endtask

    task automatic test_tmo_same_cycle();
        int t, n;
        go_idle();
        rb_tmo_sel   = 3'd0;
        rb_max_retry = 2'($urandom_range(1, 3));
        t = 256;
        cal_start = 1'b1;
        step();
        cal_start = 1'b0;
        step(GAP + 1 + (t - 3) - 1);
        dcc_done = 1'b1;
        wait_until(SIG_CD, 1'b1, 10, n);
        checks++;
        if (n !== 3 || seq_state !== 3'd4 || retry_cnt !== 2'd0) begin
            errors++; $display("[TB] FAIL tmo_same_cycle: got %0d state %0d retry %0d expected 3 4 0", n, seq_state, retry_cnt);
        end
        dcc_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_success();
        test_timeout_retry();
        test_bypass();
        test_disable();
        test_reset_mid_gap();
        test_tmo_same_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aibcr3_dcc_cal_seq.md
AIBCR3_DCC_CAL_SEQ -- requirements
Module: aibcr3_dcc_cal_seq

Interface
REQ-001 The block SHALL have parameter TMO_W, default 16, the timeout counter width.
REQ-002 The block SHALL have parameter GAP_CYC, default 8, the dcc_req-low cycles before each attempt (minimum 4).
REQ-003 clk  in  1  sequencer clock, same domain as the DCC clock.
REQ-004 nrst  in  1  reset, asynchronous, active-low.
REQ-005 rb_dcc_en  in  1  DCC enable, quasi-static CSR.
REQ-006 rb_dcc_byp  in  1  DCC bypass, quasi-static CSR.
REQ-007 rb_cont_cal  in  1  recalibrate on loss of done.
REQ-008 rb_max_retry  in  2  retries allowed after the first attempt.
REQ-009 rb_tmo_sel  in  3  timeout of 2^(rb_tmo_sel+8) cycles per attempt.
REQ-010 cal_start  in  1  core calibration request; rising edge is significant.
REQ-011 dcc_done  in  1  DCC done; asynchronous, synchronized internally.
REQ-012 dcc_req  out  1  request to the DCC; low reinitializes it.
REQ-013 cal_done  out  1  calibration complete or bypassed.
REQ-014 cal_err  out  1  calibration failed or was lost.
REQ-015 retry_cnt  out  2  retries consumed in the current sequence.
REQ-016 seq_state  out  3  current state code.

Function
REQ-017 States SHALL be IDLE=0, BYPASS=1, GAP=2, WAIT=3, DONE=4, ERR=5; codes 6-7 SHALL recover to IDLE in one cycle.
REQ-018 All outputs SHALL be decoded from registered state and counters only: dcc_req=(WAIT|DONE), cal_done=(DONE|BYPASS), cal_err=ERR.
REQ-019 dcc_done SHALL pass a 2-flop synchronizer (dcc_done_s) before use.
REQ-020 Start edge SHALL be cal_start & ~cal_start_q, where cal_start_q is a flop.
REQ-021 rb_dcc_en=0 in any state SHALL force IDLE next cycle, clear retry_cnt, and take priority over all other transitions.
REQ-022 IDLE: rb_dcc_byp=1 -> BYPASS; otherwise start edge -> GAP with retry_cnt=0.
REQ-023 BYPASS: rb_dcc_byp=0 -> IDLE; start edges ignored.
REQ-024 GAP: gap counter counts GAP_CYC cycles; exit -> WAIT only once the count completes and dcc_done_s=0, otherwise hold in GAP.
REQ-025 WAIT: timeout counter cleared on entry and incremented each cycle; dcc_done_s=1 -> DONE.
REQ-026 WAIT timeout (count = 2^(rb_tmo_sel+8)-1): retry_cnt<rb_max_retry -> retry_cnt+1, GAP; else -> ERR.
REQ-027 dcc_done_s=1 in the same cycle as timeout SHALL go to DONE, retry_cnt unchanged.
REQ-028 DONE: dcc_done_s=0 with rb_cont_cal=1 -> GAP with retry_cnt=0; with rb_cont_cal=0 -> ERR.
REQ-029 DONE or ERR: a start edge SHALL go to GAP with retry_cnt=0; start edges in GAP or WAIT SHALL be ignored.
REQ-030 Timeout and gap counters SHALL saturate and never wrap; retry_cnt SHALL never exceed rb_max_retry.

Reset
REQ-031 On nrst=0 the block SHALL asynchronously set state=IDLE and clear all counters, synchronizer flops and cal_start_q; all outputs SHALL then be 0.
REQ-032 cal_start held high across reset release SHALL count as one start edge in the first clocked cycle.

Structure
REQ-033 Package aibcr3_dcc_pkg SHALL hold the state encoding, GAP_CYC default, timeout base exponent (8) and TMO_W default.
REQ-034 The synchronizer SHALL be sub-module aibcr3_dcc_bitsync (2 flops, async active-low clear); all else inline.

Verification
REQ-035 en=1, byp=0, cal_start rises in cycle N -> dcc_req=1 from cycle N+9; dcc_done rises in cycle M -> cal_done=1, seq_state=4 from cycle M+3.
REQ-036 tmo_sel=0, max_retry=1, dcc_done tied 0 -> dcc_req high 256 cycles, low 8, high 256 -> cal_err=1, retry_cnt=1, seq_state=5.
REQ-037 en=1, byp=1 -> cal_done=1 one cycle later, dcc_req stays 0 through start pulses; byp=0 -> seq_state=0, cal_done=0.
REQ-038 en dropped during WAIT -> next cycle dcc_req=0, seq_state=0, retry_cnt=0; nrst asserted mid-GAP -> outputs 0 immediately.
REQ-039 In DONE, dcc_done falls: cont_cal=1 -> dcc_req low for 8 cycles then high again; cont_cal=0 -> cal_err=1.
REQ-040 dcc_done_s rises in the same cycle as the timeout with retry_cnt=0 -> DONE, retry_cnt stays 0.
